// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encoding, sale state machine states and
// the default drink price used by the coin controller and the dispenser.
package vend_pkg;

  // Coin encoding shared with the coin slot
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_05   = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  // Default drink price in 0.5-dollar units
  localparam int unsigned DEFAULT_PRICE_UNITS = 32'd3;

  // Sale progress states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRINK  = 2'd1,
    CHANGE = 2'd2
  } vend_state_e;

  // Greedy coin choice: a full dollar whenever at least two half-units remain
  function automatic logic [1:0] coin_sel(input logic i_ge2);
    coin_sel = i_ge2 ? COIN_10 : COIN_05;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts increment requests and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  // Count register: increment unless already saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {W{1'b0}};
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: takes one completed sale, releases the drink when the
// credit covers the price, then pays the remaining credit back coin by coin.
// A short credit skips the drink and refunds everything.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_UNITS = DEFAULT_PRICE_UNITS,
  parameter int          CREDIT_W    = 4,
  parameter int          CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CREDIT_W-1:0] req_credit,
  output logic                drink_valid,
  input  logic                drink_ready,
  output logic                coin_valid,
  output logic [1:0]          coin_type,
  input  logic                coin_ready,
  output logic                short_err,
  output logic [CNT_W-1:0]    vend_cnt,
  output logic [CNT_W-1:0]    coin_cnt
);

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);
  localparam logic [CREDIT_W-1:0] ZERO  = {CREDIT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] ONE   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO   = CREDIT_W'(2);

  vend_state_e         r_state;
  vend_state_e         w_state_nxt;
  logic [CREDIT_W-1:0] r_remain;
  logic [CREDIT_W-1:0] w_remain_nxt;
  logic [CREDIT_W-1:0] w_coin_dec;
  logic                w_short_nxt;
  logic                w_vend_inc;
  logic                w_coin_inc;

  logic                r_req_ready;
  logic                r_drink_valid;
  logic                r_coin_valid;
  logic [1:0]          r_coin_type;
  logic                r_short_err;

  // Amount taken off by the coin currently on offer (greedy)
  assign w_coin_dec = (r_remain >= TWO) ? TWO : ONE;

  // Next-state and handshake decode for the sale sequence
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_short_nxt  = 1'b0;
    w_vend_inc   = 1'b0;
    w_coin_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (req_credit >= PRICE) begin
            w_remain_nxt = req_credit - PRICE;
            w_state_nxt  = DRINK;
          end else begin
            w_remain_nxt = req_credit;
            w_short_nxt  = 1'b1;
            w_state_nxt  = (req_credit == ZERO) ? IDLE : CHANGE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DRINK: begin
        if (drink_ready) begin
          w_vend_inc  = 1'b1;
          w_state_nxt = (r_remain != ZERO) ? CHANGE : IDLE;
        end else begin
          w_state_nxt = DRINK;
        end
      end
      CHANGE: begin
        if (r_remain == ZERO) begin
          // Nothing left to pay; never offer a coin worth nothing
          w_state_nxt = IDLE;
        end else if (coin_ready) begin
          w_coin_inc   = 1'b1;
          w_remain_nxt = r_remain - w_coin_dec;
          w_state_nxt  = (w_remain_nxt == ZERO) ? IDLE : CHANGE;
        end else begin
          w_state_nxt = CHANGE;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_remain_nxt = ZERO;
      end
    endcase
  end

  // State and remaining-credit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_remain <= ZERO;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  // Output registers, decoded from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready   <= 1'b1;
      r_drink_valid <= 1'b0;
      r_coin_valid  <= 1'b0;
      r_coin_type   <= COIN_NONE;
      r_short_err   <= 1'b0;
    end else begin
      r_req_ready   <= (w_state_nxt == IDLE);
      r_drink_valid <= (w_state_nxt == DRINK);
      r_coin_valid  <= (w_state_nxt == CHANGE);
      r_coin_type   <= (w_state_nxt == CHANGE) ? coin_sel(w_remain_nxt >= TWO) : COIN_NONE;
      r_short_err   <= w_short_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_vend_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_vend_inc),
    .o_count (vend_cnt)
  );

  sat_counter #(.W(CNT_W)) u_coin_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_coin_inc),
    .o_count (coin_cnt)
  );

  assign req_ready   = r_req_ready;
  assign drink_valid = r_drink_valid;
  assign coin_valid  = r_coin_valid;
  assign coin_type   = r_coin_type;
  assign short_err   = r_short_err;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed sales with hand-computed results plus
// randomized traffic compared every cycle against a queue-based sale model.
// A second instance with 3-bit counters exercises counter saturation.
module tb_change_dispenser;

  localparam int PRICE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_credit = 4'd0;
  logic       drink_ready = 1'b0;
  logic       coin_ready = 1'b0;

  logic        req_ready, drink_valid, coin_valid, short_err;
  logic [1:0]  coin_type;
  logic [15:0] vend_cnt, coin_cnt;

  logic        s_req_ready, s_drink_valid, s_coin_valid, s_short_err;
  logic [1:0]  s_coin_type;
  logic [2:0]  s_vend_cnt, s_coin_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_credit(req_credit), .drink_valid(drink_valid), .drink_ready(drink_ready),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready),
    .short_err(short_err), .vend_cnt(vend_cnt), .coin_cnt(coin_cnt)
  );

  change_dispenser #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_credit(req_credit), .drink_valid(s_drink_valid), .drink_ready(drink_ready),
    .coin_valid(s_coin_valid), .coin_type(s_coin_type), .coin_ready(coin_ready),
    .short_err(s_short_err), .vend_cnt(s_vend_cnt), .coin_cnt(s_coin_cnt)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Sale model: a pending sale is the list of handshakes still owed
  // (0 = drink, 1 = dollar coin, 2 = half-dollar coin).
  int m_q[$];
  int m_vend = 0;
  int m_coin = 0;
  bit m_short = 1'b0;
  int m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_vend  = 0;
      m_coin  = 0;
      m_short = 1'b0;
    end else begin
      m_short = 1'b0;
      if (m_q.size() == 0) begin
        if (req_valid) begin
          m_c = int'(req_credit);
          if (m_c >= PRICE) begin
            m_q.push_back(0);
            m_c = m_c - PRICE;
          end else begin
            m_short = 1'b1;
          end
          while (m_c >= 2) begin
            m_q.push_back(1);
            m_c = m_c - 2;
          end
          if (m_c == 1) m_q.push_back(2);
        end
      end else if (m_q[0] == 0) begin
        if (drink_ready) begin
          void'(m_q.pop_front());
          m_vend++;
        end
      end else begin
        if (coin_ready) begin
          void'(m_q.pop_front());
          m_coin++;
        end
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    bit e_rr, e_dv, e_cv;
    int e_ct;
    e_rr = (m_q.size() == 0);
    e_dv = (m_q.size() != 0) && (m_q[0] == 0);
    e_cv = (m_q.size() != 0) && (m_q[0] != 0);
    e_ct = !e_cv ? 0 : ((m_q[0] == 1) ? 2 : 1);
    chk("m_req_ready",   longint'(req_ready),   longint'(e_rr));
    chk("m_drink_valid", longint'(drink_valid), longint'(e_dv));
    chk("m_coin_valid",  longint'(coin_valid),  longint'(e_cv));
    chk("m_coin_type",   longint'(coin_type),   longint'(e_ct));
    chk("m_short_err",   longint'(short_err),   longint'(m_short));
    chk("m_vend_cnt",    longint'(vend_cnt),    longint'(sat(m_vend, 65535)));
    chk("m_coin_cnt",    longint'(coin_cnt),    longint'(sat(m_coin, 65535)));
    chk("m_excl",        longint'(drink_valid & coin_valid), 64'd0);
    chk("s_outputs",
        longint'({s_req_ready, s_drink_valid, s_coin_valid, s_coin_type, s_short_err}),
        longint'({e_rr, e_dv, e_cv, e_ct[1:0], m_short}));
    chk("s_vend_cnt", longint'(s_vend_cnt), longint'(sat(m_vend, 7)));
    chk("s_coin_cnt", longint'(s_coin_cnt), longint'(sat(m_coin, 7)));
  end

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) nx();
    chk("rst_req_ready", longint'(req_ready), 64'd1);
    chk("rst_outs", longint'({drink_valid, coin_valid, coin_type, short_err}), 64'd0);
    chk("rst_cnts", longint'({vend_cnt, coin_cnt}), 64'd0);
    rst_n = 1'b1;

    // Exact price, both readies high
    nx(); req_valid = 1'b1; req_credit = 4'd3; drink_ready = 1'b1; coin_ready = 1'b1;
    nx(); req_valid = 1'b0;
    chk("t1_drink_valid", longint'(drink_valid), 64'd1);
    chk("t1_req_ready_low", longint'(req_ready), 64'd0);
    nx();
    chk("t1_idle", longint'({req_ready, drink_valid, coin_valid}), 64'b100);
    chk("t1_vend_cnt", longint'(vend_cnt), 64'd1);
    chk("t1_coin_cnt", longint'(coin_cnt), 64'd0);

    // Credit 6: drink then dollar and half-dollar back to back
    req_valid = 1'b1; req_credit = 4'd6;
    nx(); req_valid = 1'b0;
    chk("t2_drink", longint'(drink_valid), 64'd1);
    nx();
    chk("t2_coin1", longint'({coin_valid, coin_type}), 64'b110);
    nx();
    chk("t2_coin2", longint'({coin_valid, coin_type}), 64'b101);
    nx();
    chk("t2_idle", longint'({req_ready, coin_valid}), 64'b10);
    chk("t2_cnts", longint'({vend_cnt, coin_cnt}), {32'd0, 16'd2, 16'd2});

    // Credit 2: short, refunded as one dollar coin
    req_valid = 1'b1; req_credit = 4'd2;
    nx(); req_valid = 1'b0;
    chk("t3_short_err", longint'(short_err), 64'd1);
    chk("t3_coin", longint'({drink_valid, coin_valid, coin_type}), 64'b0110);
    nx();
    chk("t3_short_clear", longint'(short_err), 64'd0);
    chk("t3_cnts", longint'({vend_cnt, coin_cnt}), {32'd0, 16'd2, 16'd3});

    // Credit 4 with a stalled hopper; extra request during DRINK ignored
    req_valid = 1'b1; req_credit = 4'd4; drink_ready = 1'b0; coin_ready = 1'b0;
    nx();
    chk("t4_drink", longint'({req_ready, drink_valid}), 64'b01);
    req_valid = 1'b1; req_credit = 4'd9; drink_ready = 1'b1;
    nx(); req_valid = 1'b0; drink_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_coin_hold", longint'({coin_valid, coin_type}), 64'b101);
      nx();
    end
    coin_ready = 1'b1;
    nx();
    chk("t4_done", longint'({req_ready, coin_valid}), 64'b10);
    chk("t4_cnts", longint'({vend_cnt, coin_cnt}), {32'd0, 16'd3, 16'd4});

    // Credit 15, reset during the second coin
    drink_ready = 1'b1;
    req_valid = 1'b1; req_credit = 4'd15;
    nx(); req_valid = 1'b0;
    nx();
    nx();
    chk("t5_coin2", longint'({coin_valid, coin_type}), 64'b110);
    chk("t5_coin_cnt", longint'(coin_cnt), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", longint'({req_ready, drink_valid, coin_valid, coin_type, short_err}), 64'b100000);
    chk("t5_rst_cnts", longint'({vend_cnt, coin_cnt}), 64'd0);
    nx(); rst_n = 1'b1;
    nx(); req_valid = 1'b1; req_credit = 4'd3;
    nx(); req_valid = 1'b0;
    chk("t5_drink", longint'(drink_valid), 64'd1);
    nx();
    chk("t5_after", longint'({req_ready, vend_cnt}), {47'd0, 1'b1, 16'd1});

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      req_valid   = ($urandom_range(0, 2) == 0);
      req_credit  = 4'($urandom_range(0, 15));
      drink_ready = ($urandom_range(0, 3) != 0);
      coin_ready  = ($urandom_range(0, 3) != 0);
      nx();
    end
    req_valid = 1'b0;
    drink_ready = 1'b1;
    coin_ready = 1'b1;
    repeat (12) nx();
    chk("sat_s_vend", longint'(s_vend_cnt), 64'd7);
    chk("sat_s_coin", longint'(s_coin_cnt), 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
